// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo
//   Turns the keypad scanner's key code stream into one event per keypress.
//   Each event's 4-bit code is queued in a DEPTH-entry FIFO with a
//   valid/ready interface. The last four event codes are also kept as a
//   16-bit hex history for a seven-segment display.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   key[4:0]   scanner code: 0..15 is a debounced key, 16..31 is idle
//   clr        synchronous clear of FIFO, overflow flag and digit history
//   key_ready  consumer accepts key_out this cycle
//   key_out    code at the FIFO head (0 while empty)
//   key_valid  FIFO holds at least one entry
//   count      number of entries held, 0..DEPTH
//   overflow   sticky flag: an event was dropped because the FIFO was full
//   digits     last four event codes, newest in [3:0]
module keypad_key_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    key,
    input  logic          clr,
    input  logic          key_ready,
    output logic [3:0]    key_out,
    output logic          key_valid,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   digits
);

    localparam logic [4:0]  KEY_IDLE  = 5'd20;
    localparam logic [4:0]  KEY_MAX   = 5'd15;
    localparam logic [AW:0] COUNT_MAX = (AW+1)'(DEPTH);

    logic [4:0]    key_prev_q, key_prev_d;
    logic          armed_q, armed_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   digits_q, digits_d;
    logic [3:0]    mem_q [DEPTH];

    logic key_evt;
    logic full;
    logic empty;
    logic push;
    logic pop;

    always_comb begin
        full  = (count_q == COUNT_MAX);
        empty = (count_q == '0);

        // key_prev resets to idle, so a key held across reset release would
        // otherwise look like a fresh press. armed stays low after reset until
        // the scanner has been seen idle at least once.
        armed_d    = armed_q | (key > KEY_MAX);
        key_prev_d = key;
        key_evt    = armed_q && (key <= KEY_MAX) && (key_prev_q > KEY_MAX);

        // Full/empty come from count alone; a pop frees a slot for a push
        // arriving on the same edge.
        pop  = !clr && !empty && key_ready;
        push = !clr && key_evt && (!full || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        digits_d   = digits_q;

        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            digits_d   = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
            if (key_evt && full && !pop) overflow_d = 1'b1;
            // History follows every detected press, dropped or not.
            if (key_evt) digits_d = {digits_q[11:0], key[3:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_prev_q <= KEY_IDLE;
            armed_q    <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            key_prev_q <= key_prev_d;
            armed_q    <= armed_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            digits_q   <= digits_d;
        end
    end

    // Data array carries no reset; only the pointers and count qualify it.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= key[3:0];
    end

    // Head is masked while empty so stale storage never reaches the consumer.
    assign key_out   = empty ? 4'h0 : mem_q[rd_ptr_q];
    assign key_valid = !empty;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign digits    = digits_q;

endmodule

// File: tb/tb_keypad_key_fifo.sv
module tb_keypad_key_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  key;
    logic        clr;
    logic        key_ready;
    logic [3:0]  key_out;
    logic        key_valid;
    logic [3:0]  count;
    logic        overflow;
    logic [15:0] digits;

    int tests = 0;
    int fails = 0;
    int q[$];
    int code;

    keypad_key_fifo #(.DEPTH(8), .AW(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .clr       (clr),
        .key_ready (key_ready),
        .key_out   (key_out),
        .key_valid (key_valid),
        .count     (count),
        .overflow  (overflow),
        .digits    (digits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge, then settle past it before checking/driving.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [4:0] k);
        key = k;
        step();
        key = 5'd20;
        step();
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        key       = 5'd20;
        clr       = 1'b0;
        key_ready = 1'b0;

        #3;
        chk("rst_valid",    key_valid, 0);
        chk("rst_count",    count,     0);
        chk("rst_overflow", overflow,  0);
        chk("rst_digits",   digits,    0);
        chk("rst_key_out",  key_out,   0);
        step();
        step();
        rst = 1'b0;
        step();

        // Single press
        key = 5'd5;
        step();
        key = 5'd20;
        chk("single_valid",   key_valid, 1);
        chk("single_key_out", key_out,   5);
        chk("single_count",   count,     1);
        chk("single_digits",  digits,    16'h0005);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        chk("single_pop_valid", key_valid, 0);
        chk("single_pop_count", count,     0);

        // Held key then direct valid-to-valid change
        do_clr();
        chk("clr_digits", digits, 0);
        key = 5'd7;
        repeat (10) step();
        key = 5'd3;
        step();
        key = 5'd20;
        step();
        chk("held_count",   count,   1);
        chk("held_key_out", key_out, 7);
        chk("held_digits",  digits,  16'h0007);
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        chk("held_drained", count, 0);

        // Ordering
        do_clr();
        press(5'd1); press(5'd2); press(5'd3); press(5'd4);
        chk("order_count",  count,  4);
        chk("order_digits", digits, 16'h1234);
        key_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("order_head", key_out, i);
            step();
        end
        key_ready = 1'b0;
        chk("order_empty", key_valid, 0);

        // Pointer wrap with interleaved pops
        for (int i = 0; i < 12; i++) begin
            code = (5 + i) % 16;
            press(code[4:0]);
            q.push_back(code);
            if (i % 2 == 1) begin
                chk("wrap_head", key_out, q[0]);
                key_ready = 1'b1;
                step();
                key_ready = 1'b0;
                void'(q.pop_front());
            end
        end
        chk("wrap_count", count, q.size());
        while (q.size() > 0) begin
            chk("wrap_drain", key_out, q[0]);
            key_ready = 1'b1;
            step();
            key_ready = 1'b0;
            void'(q.pop_front());
        end
        chk("wrap_empty", key_valid, 0);

        // Overflow: nine presses into eight slots
        do_clr();
        for (int i = 0; i < 9; i++) press(5'(i));
        chk("ovf_count",   count,    8);
        chk("ovf_flag",    overflow, 1);
        chk("ovf_digits",  digits,   16'h5678);
        chk("ovf_head",    key_out,  0);
        chk("ovf_valid",   key_valid, 1);

        // Drain to three entries; overflow must stick
        key_ready = 1'b1;
        repeat (5) step();
        key_ready = 1'b0;
        chk("ovf_partial_count", count,    3);
        chk("ovf_sticky",        overflow, 1);
        chk("ovf_partial_head",  key_out,  5);

        // Clear coinciding with a new event
        key = 5'd10;
        clr = 1'b1;
        step();
        clr = 1'b0;
        key = 5'd20;
        chk("clr_count",    count,     0);
        chk("clr_valid",    key_valid, 0);
        chk("clr_overflow", overflow,  0);
        chk("clr_digits2",  digits,    0);
        step();
        chk("clr_no_store", count, 0);

        // Full FIFO: press with simultaneous pop is accepted
        for (int i = 0; i < 8; i++) press(5'(i));
        chk("full_count",  count,    8);
        chk("full_no_ovf", overflow, 0);
        chk("full_digits", digits,   16'h4567);
        key = 5'd8;
        key_ready = 1'b1;
        step();
        key = 5'd20;
        key_ready = 1'b0;
        step();
        chk("full_pop_count",  count,    8);
        chk("full_pop_no_ovf", overflow, 0);
        chk("full_pop_head",   key_out,  1);
        chk("full_pop_digits", digits,   16'h5678);
        press(5'd9);
        chk("full_drop_count",  count,    8);
        chk("full_drop_ovf",    overflow, 1);
        chk("full_drop_digits", digits,   16'h6789);
        chk("full_drop_head",   key_out,  1);

        // Async reset mid-cycle with key held
        do_clr();
        step();
        key = 5'd9;
        step();
        chk("pre_rst_valid", key_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid",    key_valid, 0);
        chk("async_count",    count,     0);
        chk("async_overflow", overflow,  0);
        chk("async_digits",   digits,    0);
        chk("async_key_out",  key_out,   0);
        #1;
        rst = 1'b0;
        step();
        step();
        chk("held_thru_rst_count",  count,  0);
        chk("held_thru_rst_digits", digits, 0);
        key = 5'd20;
        step();
        key = 5'd9;
        step();
        key = 5'd20;
        chk("post_rst_count",   count,   1);
        chk("post_rst_key_out", key_out, 9);
        chk("post_rst_digits",  digits,  16'h0009);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
